// File: rtl/multiplier_unsigned_seq.sv
// Iterative radix-2 shift-add unsigned multiplier.
// Accepts a WIDTH x WIDTH operand pair, retires one partial product per
// clock through a single WIDTH+1-bit adder, and presents the full
// 2*WIDTH-bit product until the consumer takes it.
module multiplier_unsigned_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_multiplicand,
   input  logic [WIDTH-1:0]     i_multiplier,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [2*WIDTH-1:0]   o_product,
   output logic                 o_busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic [2*WIDTH:0]   prod;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     upper_sum;

   // Conditionally add the multiplicand into the upper half, keeping the carry
   always_comb begin
      upper_sum = prod[2*WIDTH:WIDTH];
      if (prod[0]) begin
         upper_sum = prod[2*WIDTH:WIDTH] + {1'b0, mcand};
      end
   end

   // Handshake sequencing plus the shift-add datapath, one iteration per edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         prod  <= '0;
         mcand <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  mcand <= i_multiplicand;
                  prod  <= {1'b0, {WIDTH{1'b0}}, i_multiplier};
                  count <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               prod  <= {1'b0, upper_sum, prod[WIDTH-1:1]};
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status flags come straight from the state register so they never
   // depend combinationally on the handshake inputs
   always_comb begin
      o_ready   = (state == IDLE);
      o_busy    = (state == BUSY);
      o_valid   = (state == DONE);
      o_product = prod[2*WIDTH-1:0];
   end

endmodule
